// File: rtl/multi_cycle_sequencer.sv
// Stage controller for the multi-cycle CPU: walks one instruction through
// IF/ID/EXE/MEM/WB, pulses bus-register load enables, with halt and watchdog.
module multi_cycle_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             halt_req,
  input  logic             IF_over,
  input  logic             ID_over,
  input  logic             EXE_over,
  input  logic             MEM_over,
  input  logic             WB_over,
  output logic             IF_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             IF_ID_wen,
  output logic             ID_EXE_wen,
  output logic             EXE_MEM_wen,
  output logic             MEM_WB_wen,
  output logic             next_fetch,
  output logic [2:0]       cur_stage,
  output logic [CNT_W-1:0] retired,
  output logic             wdog_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wd_cnt, wd_cnt_nx;
  logic       in_stage;
  logic       stage_over;
  logic       wd_trip;

  // Valids decode the registered state only; no over-to-valid path.
  assign IF_valid  = (state == S_IF);
  assign ID_valid  = (state == S_ID);
  assign EXE_valid = (state == S_EXE);
  assign MEM_valid = (state == S_MEM);
  assign WB_valid  = (state == S_WB);

  assign IF_ID_wen   = IF_valid  & IF_over;
  assign ID_EXE_wen  = ID_valid  & ID_over;
  assign EXE_MEM_wen = EXE_valid & EXE_over;
  assign MEM_WB_wen  = MEM_valid & MEM_over;
  assign next_fetch  = WB_valid  & WB_over;

  assign cur_stage = state;
  assign in_stage  = IF_valid | ID_valid | EXE_valid | MEM_valid | WB_valid;

  always_comb begin
    stage_over = 1'b0;
    case (state)
      S_IF:    stage_over = IF_over;
      S_ID:    stage_over = ID_over;
      S_EXE:   stage_over = EXE_over;
      S_MEM:   stage_over = MEM_over;
      S_WB:    stage_over = WB_over;
      default: stage_over = 1'b0;
    endcase
  end

  assign wd_trip = in_stage & ~stage_over & (wd_cnt == WD_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = halt_req ? S_HALT : S_IF;
      S_IF:    if (IF_over)  state_nx = S_ID;
      S_ID:    if (ID_over)  state_nx = S_EXE;
      S_EXE:   if (EXE_over) state_nx = S_MEM;
      S_MEM:   if (MEM_over) state_nx = S_WB;
      S_WB:    if (WB_over)  state_nx = halt_req ? S_HALT : S_IF;
      S_HALT:  if (!halt_req) state_nx = S_IF;
      default: state_nx = S_ERR;
    endcase
    if (wd_trip) state_nx = S_ERR;
  end

  // Counter only runs while a stage is stalled; any state change clears it.
  assign wd_cnt_nx = (in_stage & ~stage_over & ~wd_trip) ? wd_cnt + 8'd1 : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
      retired  <= '0;
    end else begin
      state  <= state_nx;
      wd_cnt <= wd_cnt_nx;
      if (wd_trip)    wdog_err <= 1'b1;
      if (next_fetch) retired  <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Bench for multi_cycle_sequencer: two instances (default and TIMEOUT=4/CNT_W=4)
// checked against an arithmetic stage-index reference model.
module tb_multi_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn [2];
  logic       halt [2];
  logic [4:0] ov   [2];

  logic a_if_v, a_id_v, a_exe_v, a_mem_v, a_wb_v;
  logic a_if_w, a_id_w, a_exe_w, a_mem_w, a_nf, a_err;
  logic [2:0]  a_stage;
  logic [31:0] a_ret;
  logic b_if_v, b_id_v, b_exe_v, b_mem_v, b_wb_v;
  logic b_if_w, b_id_w, b_exe_w, b_mem_w, b_nf, b_err;
  logic [2:0]  b_stage;
  logic [3:0]  b_ret;

  logic [13:0] obs [2];
  assign obs[0] = {a_if_v, a_id_v, a_exe_v, a_mem_v, a_wb_v,
                   a_if_w, a_id_w, a_exe_w, a_mem_w, a_nf, a_stage, a_err};
  assign obs[1] = {b_if_v, b_id_v, b_exe_v, b_mem_v, b_wb_v,
                   b_if_w, b_id_w, b_exe_w, b_mem_w, b_nf, b_stage, b_err};

  multi_cycle_sequencer #(.TIMEOUT(255), .CNT_W(32)) dut_a (
    .clk(clk), .resetn(rstn[0]), .halt_req(halt[0]),
    .IF_over(ov[0][0]), .ID_over(ov[0][1]), .EXE_over(ov[0][2]),
    .MEM_over(ov[0][3]), .WB_over(ov[0][4]),
    .IF_valid(a_if_v), .ID_valid(a_id_v), .EXE_valid(a_exe_v),
    .MEM_valid(a_mem_v), .WB_valid(a_wb_v),
    .IF_ID_wen(a_if_w), .ID_EXE_wen(a_id_w), .EXE_MEM_wen(a_exe_w),
    .MEM_WB_wen(a_mem_w), .next_fetch(a_nf), .cur_stage(a_stage),
    .retired(a_ret), .wdog_err(a_err)
  );

  multi_cycle_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .resetn(rstn[1]), .halt_req(halt[1]),
    .IF_over(ov[1][0]), .ID_over(ov[1][1]), .EXE_over(ov[1][2]),
    .MEM_over(ov[1][3]), .WB_over(ov[1][4]),
    .IF_valid(b_if_v), .ID_valid(b_id_v), .EXE_valid(b_exe_v),
    .MEM_valid(b_mem_v), .WB_valid(b_wb_v),
    .IF_ID_wen(b_if_w), .ID_EXE_wen(b_id_w), .EXE_MEM_wen(b_exe_w),
    .MEM_WB_wen(b_mem_w), .next_fetch(b_nf), .cur_stage(b_stage),
    .retired(b_ret), .wdog_err(b_err)
  );

  // Reference model: stage index 0..7 (0 idle, 1..5 pipeline steps, 6 halt, 7 error).
  int              m_stage [2];
  int              m_wd    [2];
  longint unsigned m_ret   [2];
  logic            m_err   [2];

  int total = 0;
  int bad   = 0;

  function automatic int to_of(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  function automatic longint unsigned mask_of(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic longint unsigned ret_obs(input int k);
    return (k == 0) ? 64'(a_ret) : 64'(b_ret);
  endfunction

  function automatic longint unsigned exp_ret(input int k);
    return rstn[k] ? m_ret[k] : 64'd0;
  endfunction

  function automatic logic [13:0] exp_vec(input int k);
    int s;
    logic [4:0] v;
    logic [3:0] w;
    logic nf, er;
    s  = rstn[k] ? m_stage[k] : 0;
    er = rstn[k] ? m_err[k] : 1'b0;
    v  = '0;
    w  = '0;
    nf = 1'b0;
    if (s >= 1 && s <= 5) v = 5'b10000 >> (s - 1);
    if (s >= 1 && s <= 4 && ov[k][s-1]) w = 4'b1000 >> (s - 1);
    if (s == 5) nf = ov[k][4];
    return {v, w, nf, 3'(s), er};
  endfunction

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rstn[k]) begin
        m_stage[k] = 0; m_wd[k] = 0; m_ret[k] = 0; m_err[k] = 1'b0;
      end else if (m_stage[k] == 0) begin
        m_stage[k] = halt[k] ? 6 : 1;
      end else if (m_stage[k] == 6) begin
        if (!halt[k]) m_stage[k] = 1;
      end else if (m_stage[k] != 7) begin
        if (ov[k][m_stage[k]-1]) begin
          m_wd[k] = 0;
          if (m_stage[k] == 5) begin
            m_ret[k]   = (m_ret[k] + 1) & mask_of(k);
            m_stage[k] = halt[k] ? 6 : 1;
          end else begin
            m_stage[k]++;
          end
        end else if (m_wd[k] + 1 == to_of(k)) begin
          m_stage[k] = 7; m_err[k] = 1'b1; m_wd[k] = 0;
        end else begin
          m_wd[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic advance(input int k, input int target);
    int n = 0;
    while (obs[k][3:1] != 3'(target) && n < 12) begin
      step();
      n++;
    end
    total++;
    if (obs[k][3:1] != 3'(target)) begin
      bad++;
      $display("FAIL advance[%0d] stage=%0d want=%0d", k, obs[k][3:1], target);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL reset[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      step();
    end
  endtask

  task automatic test_all_over();
    rstn[0] = 1'b1; halt[0] = 1'b0; ov[0] = 5'h1F;
    for (int t = 0; t < 51; t++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL all_over[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      total++;
      if (a_stage !== 3'((t == 0) ? 0 : (t - 1) % 5 + 1)) begin
        bad++;
        $display("FAIL stage_seq t=%0d got=%0d", t, a_stage);
      end
      if (t == 6) begin
        total++;
        if (a_ret !== 32'd1) begin bad++; $display("FAIL retired_first got=%0d want=1", a_ret); end
      end
      step();
    end
    total++;
    if (a_ret !== 32'd10) begin bad++; $display("FAIL retired_ten got=%0d want=10", a_ret); end
  endtask

  task automatic test_stall();
    int exe_n = 0, wen_n = 0, other = 0, wen_at = -1;
    advance(0, 3);
    ov[0][2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) ov[0][2] = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL stall[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      if (a_exe_v) exe_n++;
      if (a_exe_w) begin wen_n++; wen_at = c; end
      if (a_if_v | a_id_v | a_mem_v | a_wb_v) other++;
      step();
    end
    total++;
    if (exe_n != 8 || wen_n != 1 || wen_at != 7 || other != 0) begin
      bad++;
      $display("FAIL stall_counts exe=%0d wen=%0d at=%0d other=%0d want 8/1/7/0", exe_n, wen_n, wen_at, other);
    end
  endtask

  task automatic test_halt();
    longint unsigned base;
    advance(0, 2);
    base = m_ret[0];
    halt[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL halt[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      step();
    end
    total++;
    if (a_stage !== 3'd6 || {a_if_v, a_id_v, a_exe_v, a_mem_v, a_wb_v} !== 5'b0 ||
        64'(a_ret) !== ((base + 1) & 64'hFFFF_FFFF)) begin
      bad++;
      $display("FAIL halt_state stage=%0d ret=%0d want stage=6 ret=%0d", a_stage, a_ret, base + 1);
    end
    halt[0] = 1'b0;
    #1;
    total++;
    if (a_if_v !== 1'b0 || a_stage !== 3'd6) begin
      bad++; $display("FAIL halt_hold if_valid=%b stage=%0d want 0/6", a_if_v, a_stage);
    end
    step();
    total++;
    if (a_if_v !== 1'b1) begin bad++; $display("FAIL halt_release if_valid=%b want 1", a_if_v); end
  endtask

  task automatic test_reset_mid_wb();
    advance(0, 5);
    #1;
    total++;
    if (obs[0] !== exp_vec(0) || a_nf !== 1'b1) begin
      bad++; $display("FAIL pre_reset got=%b want=%b", obs[0], exp_vec(0));
    end
    rstn[0] = 1'b0;
    #1;
    total++;
    if (obs[0] !== 14'b0 || a_ret !== 32'd0) begin
      bad++; $display("FAIL async_reset got=%b ret=%0d want all 0", obs[0], a_ret);
    end
    step();
    rstn[0] = 1'b1;
    #1;
    total++;
    if (a_stage !== 3'd0 || obs[0] !== exp_vec(0)) begin
      bad++; $display("FAIL restart_idle stage=%0d want 0", a_stage);
    end
    step();
    total++;
    if (a_stage !== 3'd1 || a_if_v !== 1'b1) begin
      bad++; $display("FAIL restart_if stage=%0d want 1", a_stage);
    end
  endtask

  task automatic test_watchdog();
    rstn[1] = 1'b1; halt[1] = 1'b0; ov[1] = 5'h1F;
    advance(1, 4);
    ov[1][3] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) ov[1] = 5'h1F;
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL wdog[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      if (c == 4) begin
        total++;
        if (b_stage !== 3'd7 || b_err !== 1'b1 || b_mem_v !== 1'b0 || b_mem_w !== 1'b0) begin
          bad++; $display("FAIL wdog_trip stage=%0d err=%b mem_v=%b want 7/1/0", b_stage, b_err, b_mem_v);
        end
      end
      step();
    end
    total++;
    if (b_stage !== 3'd7 || b_err !== 1'b1) begin
      bad++; $display("FAIL wdog_sticky stage=%0d err=%b want 7/1", b_stage, b_err);
    end
    rstn[1] = 1'b0;
    #1;
    total++;
    if (b_err !== 1'b0 || b_stage !== 3'd0) begin
      bad++; $display("FAIL wdog_clear err=%b stage=%0d want 0/0", b_err, b_stage);
    end
    step();
  endtask

  task automatic test_wrap();
    rstn[1] = 1'b1; ov[1] = 5'h1F;
    for (int t = 0; t < 86; t++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL wrap[%0d] got=%b/%0d want=%b/%0d", k, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
      end
      step();
    end
    total++;
    if (b_ret !== 4'd1) begin bad++; $display("FAIL retired_wrap got=%0d want=1", b_ret); end
    ov[1] = 5'b00010;
    #1;
    total++;
    if (b_id_w !== 1'b0 || b_if_w !== 1'b0 || b_stage !== 3'd1) begin
      bad++; $display("FAIL stray_over id_wen=%b stage=%0d want 0/1", b_id_w, b_stage);
    end
    step();
    total++;
    if (b_stage !== 3'd1 || b_if_v !== 1'b1) begin
      bad++; $display("FAIL stray_hold stage=%0d want 1", b_stage);
    end
    ov[1] = 5'h1F;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        ov[k]   = 5'($urandom | $urandom);
        halt[k] = ($urandom_range(0, 9) == 0);
        rstn[k] = ($urandom_range(0, 99) != 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_vec(k) || ret_obs(k) !== exp_ret(k)) begin
          bad++;
          $display("FAIL random[%0d] c=%0d got=%b/%0d want=%b/%0d", k, c, obs[k], ret_obs(k), exp_vec(k), exp_ret(k));
        end
        total++;
        if ($countones(obs[k][13:9]) > 1 || $countones(obs[k][8:5]) > 1) begin
          bad++; $display("FAIL onehot[%0d] c=%0d got=%b want at most one valid/wen", k, c, obs[k]);
        end
      end
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; halt[k] = 1'b0; ov[k] = 5'h1F;
      m_stage[k] = 0; m_wd[k] = 0; m_ret[k] = 0; m_err[k] = 1'b0;
    end
    test_reset();
    test_all_over();
    test_stall();
    test_halt();
    test_reset_mid_wb();
    test_watchdog();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
